// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multicycle CPU divide path.
//   div_state_e      : divider FSM state encoding
//   DIV_LATENCY      : edges from the accepting edge to the DivStop cycle (normal divide)
//   DIV_ZERO_LATENCY : same, for divide-by-zero
package cpu_pkg;
  localparam int DIV_WIDTH        = 32;
  localparam int DIV_LATENCY      = 34;
  localparam int DIV_ZERO_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    SIGN = 3'd2,
    DONE = 3'd3,
    ZERO = 3'd4
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   rem_in  : partial remainder (always < divisor)
//   quo_in  : dividend/quotient shift register; its MSB feeds the remainder
//   divisor : divisor magnitude
//   rem_out : new partial remainder
//   quo_out : quo_in shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit so a divisor magnitude of 2^(WIDTH-1) cannot overflow the compare.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  // trial MSB set means the subtraction went negative: restore.
  assign rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_seq.sv
// div_seq: sequential signed divider (MIPS DIV: LO = quotient, HI = remainder).
// Restoring radix-2 on magnitudes, one quotient bit per cycle, then sign fix-up.
// Ports:
//   clk, reset   : clock; synchronous active-low reset
//   DivCtrl      : start request, accepted only in IDLE
//   A, B         : dividend / divisor, captured on the accepting edge
//   DivUnsigned  : (only with DIV_UNSIGNED_EN) 1 = unsigned divide, captured with DivCtrl
//   DivBusy      : high from the edge after acceptance through the DivStop cycle
//   DivStop      : one-cycle done pulse
//   DivZero      : one-cycle pulse with DivStop when B == 0
//   DivHOut      : remainder, held until the next completed divide
//   DivLOut      : quotient, held until the next completed divide
// Build option: define DIV_UNSIGNED_EN to add the DivUnsigned port.
module div_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_UNSIGNED_EN
  input  logic             DivUnsigned,
`endif
  output logic             DivBusy,
  output logic             DivStop,
  output logic             DivZero,
  output logic [WIDTH-1:0] DivHOut,
  output logic [WIDTH-1:0] DivLOut
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             rneg_q, qneg_q;
  logic             busy_q, stop_q, zero_q;

  logic             sgn_mode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_d, quo_d;

`ifdef DIV_UNSIGNED_EN
  assign sgn_mode = ~DivUnsigned;
`else
  assign sgn_mode = 1'b1;
`endif

  // Magnitude of 0x80000000 is 0x80000000 read as unsigned, so WIDTH bits suffice.
  assign a_neg = sgn_mode & A[WIDTH-1];
  assign b_neg = sgn_mode & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(rem_d),
    .quo_out(quo_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DivCtrl) begin
            dvs_q   <= b_mag;
            quo_q   <= a_mag;
            rem_q   <= '0;
            rneg_q  <= a_neg;
            qneg_q  <= a_neg ^ b_neg;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= (B == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= SIGN;
        end
        SIGN: begin
          lo_q    <= qneg_q ? -quo_q : quo_q;
          hi_q    <= rneg_q ? -rem_q : rem_q;
          state_q <= DONE;
        end
        // DONE/ZERO are held across the pulse cycle so a start request
        // arriving together with DivStop is not accepted.
        DONE: begin
          if (!stop_q) begin
            stop_q <= 1'b1;
          end else begin
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ZERO: begin
          if (!stop_q) begin
            stop_q <= 1'b1;
            zero_q <= 1'b1;
          end else begin
            stop_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DivBusy = busy_q;
  assign DivStop = stop_q;
  assign DivZero = zero_q;
  assign DivHOut = hi_q;
  assign DivLOut = lo_q;
endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DivCtrl = 1'b0;
  logic [31:0] A = '0, B = '0;
`ifdef DIV_UNSIGNED_EN
  logic        DivUnsigned = 1'b0;
`endif
  logic        DivBusy, DivStop, DivZero;
  logic [31:0] DivHOut, DivLOut;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .DivCtrl(DivCtrl), .A(A), .B(B),
`ifdef DIV_UNSIGNED_EN
    .DivUnsigned(DivUnsigned),
`endif
    .DivBusy(DivBusy), .DivStop(DivStop), .DivZero(DivZero),
    .DivHOut(DivHOut), .DivLOut(DivLOut)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_done = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  logic busy_bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: compares every DivStop pulse against the oldest expected entry.
  always @(negedge clk) begin
    if (reset && DivStop === 1'b1) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_stop: DivStop with no divide outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("LO", DivLOut, e.lo);
        chk("HI", DivHOut, e.hi);
        chk("zero", {31'b0, DivZero}, {31'b0, e.zero});
        chk("latency", cyc - e.start, e.lat);
        chk("busy_at_stop", {31'b0, DivBusy}, 32'd1);
      end
      n_done++;
    end
  end

  // Stimulus acts 2 time units after the falling edge, after the monitor.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo,
                       input logic [31:0] hi, input logic zero, input logic uns);
    exp_t e;
    step();
    A = a; B = b; DivCtrl = 1'b1;
`ifdef DIV_UNSIGNED_EN
    DivUnsigned = uns;
`else
    if (uns) $display("note: unsigned request ignored in signed-only build");
`endif
    e.lo = lo; e.hi = hi; e.zero = zero; e.start = cyc + 1;
    e.lat = zero ? 1 : 34;
    sb.push_back(e);
    busy_bad = 1'b0;
    step();
    DivCtrl = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 100) begin
      if (DivBusy !== 1'b1) busy_bad = 1'b1;
      step();
      k++;
    end
    if (n_done < target) begin
      chk_cnt++;
      $display("FAIL timeout: done count %0d expected %0d", n_done, target);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo,
                     input logic [31:0] hi, input logic zero);
    int t;
    t = n_done + 1;
    issue(a, b, lo, hi, zero, 1'b0);
    wait_done(t);
    chk("busy_throughout", {31'b0, busy_bad}, 32'd0);
    step();
  endtask

  initial begin
    int t;
    busy_bad = 1'b0;
    repeat (3) step();
    chk("rst_busy", {31'b0, DivBusy}, 32'd0);
    chk("rst_stop", {31'b0, DivStop}, 32'd0);
    chk("rst_zero", {31'b0, DivZero}, 32'd0);
    chk("rst_hi", DivHOut, 32'd0);
    chk("rst_lo", DivLOut, 32'd0);
    reset = 1'b1;
    step();

    run(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    run(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0);

    // Divide by zero keeps the previous result.
    run(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    run(32'd5, 32'd0, 32'd3, 32'd1, 1'b1);

    // Start request mid-divide must be ignored.
    t = n_done + 1;
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    repeat (9) step();
    A = 32'd1; B = 32'd1; DivCtrl = 1'b1;
    step();
    DivCtrl = 1'b0;
    wait_done(t);
    chk("ignored_extra_start", sb.size(), 32'd0);
    repeat (5) step();
    chk("no_queued_start", {31'b0, DivBusy}, 32'd0);

    // Reset mid-divide: outputs cleared, no DivStop for the aborted divide.
    step();
    A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
    step();
    DivCtrl = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    chk("abort_busy", {31'b0, DivBusy}, 32'd0);
    chk("abort_stop", {31'b0, DivStop}, 32'd0);
    chk("abort_hi", DivHOut, 32'd0);
    chk("abort_lo", DivLOut, 32'd0);
    reset = 1'b1;
    repeat (45) step();
    run(32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 32'd1, 1'b0);
    run(32'hFFFFFC18, 32'hFFFFFFFD, 32'h0000014D, 32'hFFFFFFFF, 1'b0);

    // DivCtrl held high: a second divide starts 36 edges after the first.
    begin
      exp_t e;
      int n0;
      n0 = n_done;
      step();
      A = 32'hFFFFFFF7; B = 32'd4; DivCtrl = 1'b1;
      e.lo = 32'hFFFFFFFE; e.hi = 32'hFFFFFFFF; e.zero = 1'b0; e.lat = 34;
      e.start = cyc + 1;
      sb.push_back(e);
      e.start = cyc + 37;
      sb.push_back(e);
      wait_done(n0 + 1);
      step();
      step();
      DivCtrl = 1'b0;
      wait_done(n0 + 2);
      step();
    end

`ifdef DIV_UNSIGNED_EN
    t = n_done + 1;
    issue(32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
    wait_done(t);
    DivUnsigned = 1'b0;
    step();
`endif

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
